// File: rtl/stl_stream_unloader.sv
// Serializes a triangle mesh from word memory as a binary STL byte stream.
// Define STL_NORMAL_PASS_EN to fetch per-triangle normals from memory (12-word records).
module stl_stream_unloader #(
  parameter int unsigned        ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  COUNT_ADDR = 16'h8001,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 16'h800B,
  parameter logic [7:0]         HDR_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

`ifdef STL_NORMAL_PASS_EN
  localparam int unsigned NumWords = 12;
`else
  localparam int unsigned NumWords = 9;
`endif
  localparam logic [3:0] LastWord = 4'(NumWords - 1);

  typedef enum logic [3:0] {
    StIdle, StHdr, StCntRd, StCntLat, StCntTx, StNrm, StWRd, StWLat, StWTx, StAttr, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        bcnt_q, bcnt_d;
  logic [31:0]       sh_q, sh_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       tri_q, tri_d;
  logic [3:0]        widx_q, widx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hs;

  assign hs       = tx_valid && tx_ready;
  assign mem_addr = addr_q;
  assign busy     = (state_q != StIdle) && (state_q != StFin);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      tri_q   <= '0;
      widx_q  <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tri_q   <= tri_d;
      widx_q  <= widx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    tri_d    = tri_q;
    widx_d   = widx_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    mem_rd   = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
          bcnt_d  = '0;
        end
      end
      StHdr: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (hs) begin
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd79) begin
            state_d = StCntRd;
            addr_d  = COUNT_ADDR;
          end
        end
      end
      StCntRd: begin
        mem_rd  = 1'b1;
        state_d = StCntLat;
      end
      StCntLat: begin
        cnt_d   = mem_rdata;
        sh_d    = mem_rdata;
        bcnt_d  = '0;
        state_d = StCntTx;
      end
      StCntTx: begin
        tx_valid = 1'b1;
        tx_data  = sh_q[7:0];
        if (hs) begin
          sh_d   = {8'h00, sh_q[31:8]};
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd3) begin
            bcnt_d = '0;
            if (cnt_q == 32'd0) begin
              state_d = StFin;
            end else begin
              ptr_d  = BASE_ADDR;
              tri_d  = cnt_q;
              widx_d = '0;
`ifdef STL_NORMAL_PASS_EN
              state_d = StWRd;
              addr_d  = BASE_ADDR;
`else
              state_d = StNrm;
`endif
            end
          end
        end
      end
      // Zero normal: 12 bytes emitted without touching memory.
      StNrm: begin
        tx_valid = 1'b1;
        if (hs) begin
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd11) begin
            state_d = StWRd;
            addr_d  = ptr_q;
          end
        end
      end
      StWRd: begin
        mem_rd  = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        state_d = StWLat;
      end
      StWLat: begin
        sh_d    = mem_rdata;
        bcnt_d  = '0;
        state_d = StWTx;
      end
      StWTx: begin
        tx_valid = 1'b1;
        tx_data  = sh_q[7:0];
        if (hs) begin
          sh_d   = {8'h00, sh_q[31:8]};
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd3) begin
            bcnt_d = '0;
            widx_d = widx_q + 4'd1;
            if (widx_q == LastWord) begin
              state_d = StAttr;
            end else begin
              state_d = StWRd;
              addr_d  = ptr_q;
            end
          end
        end
      end
      StAttr: begin
        tx_valid = 1'b1;
        if (hs) begin
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd1) begin
            bcnt_d = '0;
            tri_d  = tri_q - 32'd1;
            widx_d = '0;
            if (tri_q == 32'd1) begin
              state_d = StFin;
            end else begin
`ifdef STL_NORMAL_PASS_EN
              state_d = StWRd;
              addr_d  = ptr_q;
`else
              state_d = StNrm;
`endif
            end
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_stl_stream_unloader.sv
// Scoreboard bench for stl_stream_unloader: expected bytes queued up front, monitor pops on handshake.
module tb_stl_stream_unloader;
  logic        clk = 1'b0;
  logic        reset, start, busy, done, mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  always #5 clk = ~clk;

  stl_stream_unloader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx[$];
  int          done_cnt = 0;
  bit          base_rd = 0;
  bit          saw_8017 = 0;
  bit          rand_ready = 0;
  logic [31:0] mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
  endfunction

  function automatic void push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endfunction

  // Reference stream: header, count, then records from memory.
  function automatic void push_stream(input int n);
    logic [15:0] p;
    for (int i = 0; i < 80; i++) exp_q.push_back(8'h00);
    push_word(32'(n));
    p = 16'h800B;
    for (int t = 0; t < n; t++) begin
`ifdef STL_NORMAL_PASS_EN
      for (int w = 0; w < 12; w++) begin push_word(rd(p)); p = p + 16'd1; end
`else
      for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
      for (int w = 0; w < 9; w++) begin push_word(rd(p)); p = p + 16'd1; end
`endif
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
    end
  endfunction

  // Memory model: one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (mem_rd) mem_rdata <= rd(mem_addr);
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    bit         stall_q;
    logic [7:0] stall_data;
    stall_q = 0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_q = 0;
      end else begin
        if (done) done_cnt++;
        if (mem_rd && mem_addr == 16'h800B) base_rd = 1;
        if (mem_rd && mem_addr == 16'h8017) saw_8017 = 1;
        if (stall_q) begin
          check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
          check("stall_data_held", {24'd0, tx_data}, {24'd0, stall_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_byte: got %h, expected no byte", tx_data);
          end else begin
            check("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
          end
          rx.push_back(tx_data);
        end
        stall_q = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic prep(input int n);
    exp_q.delete();
    rx.delete();
    done_cnt = 0;
    base_rd = 0;
    saw_8017 = 0;
    mem[32'h8001] = 32'(n);
    push_stream(n);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 20000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt), 32'(target));
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rx(input int nbytes);
    int n = 0;
    while (rx.size() < nbytes && n < 20000) begin @(negedge clk); n++; end
    check("wait_rx_bound", {31'd0, rx.size() >= nbytes}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    check({name, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({name, "_tx_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 36; i++) mem[32'h800B + i] = 32'h3F80_0000 + 32'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // count = 0: header + count only, first byte one cycle after start
    prep(0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("first_byte_latency", {31'd0, tx_valid}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(1, "cnt0");
    check("cnt0_total", 32'(rx.size()), 32'd84);
    check("cnt0_no_base_read", {31'd0, base_rd}, 32'd0);
    check("cnt0_busy_low", {31'd0, busy}, 32'd0);

    // count = 1, always ready
    prep(1);
    pulse_start();
    wait_done(1, "cnt1");
    check("cnt1_total", 32'(rx.size()), 32'd134);
    if (rx.size() == 134) begin
`ifndef STL_NORMAL_PASS_EN
      check("cnt1_nrm_first", {24'd0, rx[84]}, 32'h00);
      check("cnt1_nrm_last", {24'd0, rx[95]}, 32'h00);
      check("cnt1_b96", {24'd0, rx[96]}, 32'h00);
      check("cnt1_b97", {24'd0, rx[97]}, 32'h00);
      check("cnt1_b98", {24'd0, rx[98]}, 32'h80);
      check("cnt1_b99", {24'd0, rx[99]}, 32'h3F);
`endif
      check("cnt1_attr0", {24'd0, rx[132]}, 32'h00);
      check("cnt1_attr1", {24'd0, rx[133]}, 32'h00);
    end

    // count = 3 with a stalling sink
    prep(3);
    rand_ready = 1;
    pulse_start();
    wait_done(1, "cnt3");
    rand_ready = 0;
    check("cnt3_total", 32'(rx.size()), 32'd234);
`ifdef STL_NORMAL_PASS_EN
    check("cnt3_last_addr", {16'd0, mem_addr}, 32'h802E);
`else
    check("cnt3_last_addr", {16'd0, mem_addr}, 32'h8025);
`endif

    // start while busy is ignored
    prep(1);
    pulse_start();
    wait_rx(40);
    pulse_start();
    wait_done(1, "restart");
    check("restart_total", 32'(rx.size()), 32'd134);

    // reset mid-record, then a clean rerun
    prep(2);
    pulse_start();
    wait_rx(100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    prep(2);
    pulse_start();
    wait_done(1, "after_reset");
    check("after_reset_total", 32'(rx.size()), 32'd184);

`ifdef STL_NORMAL_PASS_EN
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 3; w++) mem[32'h800B + 12 * t + w] = 32'h1111_1111;
      for (int w = 3; w < 12; w++) mem[32'h800B + 12 * t + w] = 32'hA000_0000 + 32'(16 * t + w);
    end
    prep(2);
    pulse_start();
    wait_done(1, "nrm");
    check("nrm_total", 32'(rx.size()), 32'd184);
    if (rx.size() == 184) begin
      for (int i = 84; i < 88; i++) check("nrm_byte", {24'd0, rx[i]}, 32'h11);
    end
    check("nrm_second_rec_read", {31'd0, saw_8017}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stl_stream_unloader.md
# stl_stream_unloader

Synthesizable unloader that reads a triangle mesh out of the 32-bit word memory and serializes it as a binary STL byte stream. It is the return path for the transformed-mesh flow: once the compute engines finish, firmware pulses `start` and this block walks the triangle count word and the vertex records, emitting the 80-byte header, the little-endian count, and 50-byte triangle records. Output goes over a valid/ready byte interface to a host link or file sink.

## Interface
- `ADDR_W`, 16: word-address width of the memory read port.
- `COUNT_ADDR`, 16'h8001: word address of the 32-bit triangle count.
- `BASE_ADDR`, 16'h800B: word address of the first word of triangle 0.
- `HDR_BYTE`, 8'h00: value emitted for each of the 80 header bytes.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to begin an unload; ignored unless idle.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final byte handshake.
- `mem_rd`  out  1  word read strobe.
- `mem_addr`  out  ADDR_W  word address, valid with `mem_rd`.
- `mem_rdata`  in  32  read data, valid exactly one cycle after `mem_rd`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts; transfer when `tx_valid && tx_ready`.

## Operation
- States: IDLE, HDR, CNT_RD, CNT_LAT, CNT_TX, W_RD, W_LAT, W_TX, ATTR, FIN.
- IDLE: `start` -> HDR, `busy`=1, byte counter=0.
- HDR: emit `HDR_BYTE` 80 times -> CNT_RD.
- CNT_RD: `mem_rd`=1, `mem_addr`=COUNT_ADDR -> CNT_LAT: latch `mem_rdata` into count register and shift register -> CNT_TX: emit 4 bytes, LSB first. Count==0 -> FIN; else word pointer=BASE_ADDR, tri counter=count, word index=0 -> record start.
- Record start (macro off): emit 12 zero bytes (normal) in W_TX-equivalent zero path, then W_RD.
- W_RD: `mem_rd`=1, `mem_addr`=pointer, pointer+=1 -> W_LAT: latch word -> W_TX: emit 4 bytes LSB first; word index+1; after 9 vertex words -> ATTR; else W_RD.
- ATTR: emit two 8'h00 bytes; tri counter-1; zero -> FIN, else next record.
- FIN: `done`=1 one cycle, `busy`=0 -> IDLE.
- Vertex word order per triangle: x1,y1,z1,x2,y2,z2,x3,y3,z3; pointer stride 9 words.
- Total bytes = 84 + 50*count; count treated as unsigned 32-bit; pointer wraps modulo 2^ADDR_W without error.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0, `tx_valid`=0, `tx_data`=0; state IDLE.
- `start` -> first header byte valid 1 cycle later.
- `tx_data` held stable while `tx_valid && !tx_ready`; `tx_valid` never deasserts without handshake.
- Each memory word costs 2 non-emitting cycles (RD, LAT) before its 4 bytes; no prefetch.
- `mem_rd` is a one-cycle pulse; never asserted while `tx_valid` is pending.
- `start` while busy or coincident with `done`: ignored.
- `reset` mid-operation: next cycle all outputs at reset values, partially sent record abandoned.

## Configuration
- `STL_NORMAL_PASS_EN` defined: each memory record is 12 words, nx,ny,nz then 9 vertex words; normals fetched and emitted from memory like vertex words; stride 12.
- Undefined: records are 9 words; normal emitted as 12 zero bytes without memory reads; stride 9.

## Test plan
- count=0, `tx_ready`=1 -> exactly 84 bytes, bytes 0..79=`HDR_BYTE`, 80..83=00, `done` pulse, no `mem_rd` to BASE_ADDR.
- count=1, words 0x800B..0x8013 = 0x3F800000+i -> 134 bytes; byte 84..95=00; byte 96..99 = 00,00,80,3F; byte 132..133=00.
- count=3, `tx_ready` random 30% -> byte stream identical to the `tx_ready`=1 run; `tx_data` stable during stalls; `mem_addr` ends at 0x8025.
- `start` pulsed again at byte 40 -> ignored, total still 84+50*N, single `done`.
- `reset` asserted at byte 100 of count=2 -> outputs at reset values next cycle; new `start` yields full correct stream.
- With `STL_NORMAL_PASS_EN`, count=2, normals 0x11111111 -> bytes 84..87=11, second record reads from 0x8017.
